ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port pc_load, input, 1 bit: redirect instruction stream to pc_in.
REQ-004 SHALL have port pc_in, input, 32 bits: new byte address, sampled when pc_load=1.
REQ-005 SHALL have port consume1, input, 1 bit: controlpath consumed 1 byte (mbr1).
REQ-006 SHALL have port consume2, input, 1 bit: controlpath consumed 2 bytes (mbr2).
REQ-007 SHALL have port mem_req, output, 1 bit: word fetch request.
REQ-008 SHALL have port mem_addr, output, 30 bits: word address of the fetch.
REQ-009 SHALL have port mem_ack, input, 1 bit: fetch complete; mem_rdata valid in the same cycle.
REQ-010 SHALL have port mem_rdata, input, 32 bits: fetched word, lowest-address byte in [31:24].
REQ-011 SHALL have port mbr1, output, 8 bits: next unconsumed opcode/operand byte, feeds controlpath MBR.
REQ-012 SHALL have port mbr2, output, 16 bits: {byte0, byte1} of the buffer (big-endian).
REQ-013 SHALL have port mbr1_valid, output, 1 bit: at least 1 byte buffered.
REQ-014 SHALL have port mbr2_valid, output, 1 bit: at least 2 bytes buffered.
REQ-015 SHALL have port pc, output, 32 bits: byte address of mbr1.

Function
REQ-016 SHALL hold an 8-byte queue with count 0..8; byte0 is the oldest.
REQ-017 SHALL drive mbr1/mbr2 combinationally from queue bytes 0/1; bytes beyond count are don't-care.
REQ-018 SHALL assert mbr1_valid = (count>=1), mbr2_valid = (count>=2).
REQ-019 SHALL raise mem_req the cycle after count<=4 with no request outstanding, and hold mem_req and mem_addr stable until the mem_ack cycle inclusive.
REQ-020 SHALL deassert mem_req in the cycle after mem_ack; at most one request outstanding.
REQ-021 SHALL increment mem_addr (fetch word pointer) by 1 per accepted word, wrapping 3FFFFFFF->0.
REQ-022 SHALL append all 4 bytes of mem_rdata on mem_ack, except for the first word after a redirect, where the leading skip=pc_in[1:0] bytes are dropped (append 4-skip).
REQ-023 SHALL remove 1 byte and add 1 to pc on consume1 when count>=1; ignore it when count=0.
REQ-024 SHALL remove 2 bytes and add 2 to pc on consume2 when count>=2; ignore it when count<2.
REQ-025 SHALL treat consume1 and consume2 both high as consume2.
REQ-026 SHALL apply consume and mem_ack in the same cycle together: remove from the head first, append after the remaining bytes; count' = count - removed + added, never above 8.
REQ-027 SHALL, on pc_load, set count=0, pc=pc_in, fetch pointer=pc_in[31:2] and skip=pc_in[1:0].
REQ-028 SHALL give pc_load priority over consume1/consume2 and over mem_ack in the same cycle.
REQ-029 SHALL, when pc_load occurs with a request outstanding (including the ack cycle itself), keep mem_req/mem_addr until that ack, discard its data, and then issue the new fetch.
REQ-030 SHALL wrap pc modulo 2^32.

Reset
REQ-031 SHALL, while rst=0, force count=0, pc=0, fetch pointer=0, skip=0, mem_req=0, mem_addr=0, mbr1=0, mbr2=0, valids=0, and discard pending state.
REQ-032 SHALL issue the first request (mem_addr=0) in the first clock edge after rst rises.
REQ-033 SHALL abandon an outstanding request on reset assertion mid-fetch, with no data retained.

Verification
REQ-034 SHALL pass: reset release, mem_ack after 2 cycles with rdata=0x10A7_3C59 -> mbr1=0x10, mbr2=0x10A7, count=4, second request at mem_addr=1.
REQ-035 SHALL pass: count=4 and consume2 coincide with ack of 0x1122_3344 -> count=6, the next two bytes after the old bytes are 0x11,0x22, pc+=2.
REQ-036 SHALL pass: pc_load with pc_in=0x0000_0106 -> mem_addr=0x41, after ack of 0xAABB_CCDD count=2, mbr2=0xCCDD, pc=0x106.
REQ-037 SHALL pass: pc_load during an outstanding fetch -> stale ack ignored (count stays 0), the new request is issued the next cycle.
REQ-038 SHALL pass: count=1 with consume2 -> ignored; count=0 with consume1 -> ignored; pc unchanged in both cases.
REQ-039 SHALL pass: rst=0 asynchronously mid-fetch -> all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/ifu.sv
// Instruction fetch unit: an 8-byte prefetch queue that feeds the controlpath MBR bytes.
// It refills one 32-bit word at a time from memory and is redirected by pc_load.
module ifu (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    input  logic        consume1,
    input  logic        consume2,
    output logic        mem_req,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [7:0]  mbr1,
    output logic [15:0] mbr2,
    output logic        mbr1_valid,
    output logic        mbr2_valid,
    output logic [31:0] pc
);

    logic [7:0]  buf_q [8];
    logic [7:0]  buf_d [8];
    logic [3:0]  count_q, count_d;
    logic [31:0] pc_q, pc_d;
    logic [29:0] fptr_q, fptr_d;
    logic [29:0] addr_q, addr_d;
    logic [1:0]  skip_q, skip_d;
    logic        req_q, req_d;
    logic        stale_q, stale_d;

    logic [1:0]  rem;
    logic        take;
    logic [2:0]  add;
    logic [3:0]  base;
    logic [3:0]  idx;

    always_comb begin
        rem = 2'd0;
        if (consume2 && count_q >= 4'd2) begin
            rem = 2'd2;
        end else if (consume1 && count_q >= 4'd1) begin
            rem = 2'd1;
        end
    end

    // A stale ack answers a request issued before the last redirect; its data is dropped.
    assign take = req_q && mem_ack && !stale_q && !pc_load;
    assign add  = take ? (3'd4 - {1'b0, skip_q}) : 3'd0;
    assign base = count_q - {2'b00, rem};

    always_comb begin
        idx = 4'd0;
        for (int i = 0; i < 8; i++) begin
            buf_d[i] = 8'h00;
        end
        case (rem)
            2'd1: begin
                for (int i = 0; i < 7; i++) buf_d[i] = buf_q[i + 1];
            end
            2'd2: begin
                for (int i = 0; i < 6; i++) buf_d[i] = buf_q[i + 2];
            end
            default: begin
                for (int i = 0; i < 8; i++) buf_d[i] = buf_q[i];
            end
        endcase
        if (take) begin
            for (int j = 0; j < 4; j++) begin
                if (2'(j) >= skip_q) begin
                    idx = base + 4'(j) - {2'b00, skip_q};
                    if (idx < 4'd8) begin
                        buf_d[idx[2:0]] = mem_rdata[31 - 8*j -: 8];
                    end
                end
            end
        end
    end

    always_comb begin
        count_d = count_q - {2'b00, rem} + {1'b0, add};
        pc_d    = pc_q + {30'd0, rem};
        fptr_d  = fptr_q;
        skip_d  = skip_q;
        stale_d = stale_q;
        if (take) begin
            fptr_d = fptr_q + 30'd1;
            skip_d = 2'd0;
        end
        if (req_q && mem_ack) begin
            stale_d = 1'b0;
        end
        if (pc_load) begin
            count_d = 4'd0;
            pc_d    = pc_in;
            fptr_d  = pc_in[31:2];
            skip_d  = pc_in[1:0];
            if (req_q && !mem_ack) begin
                stale_d = 1'b1;
            end
        end
    end

    // Request handshake: hold address until the ack, then a one-cycle gap before the next.
    always_comb begin
        req_d  = req_q;
        addr_d = addr_q;
        if (req_q) begin
            if (mem_ack) begin
                req_d = 1'b0;
            end
        end else if (count_q <= 4'd4 && !pc_load) begin
            req_d  = 1'b1;
            addr_d = fptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= 8'h00;
            end
            count_q <= 4'd0;
            pc_q    <= 32'd0;
            fptr_q  <= 30'd0;
            addr_q  <= 30'd0;
            skip_q  <= 2'd0;
            req_q   <= 1'b0;
            stale_q <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                buf_q[i] <= buf_d[i];
            end
            count_q <= count_d;
            pc_q    <= pc_d;
            fptr_q  <= fptr_d;
            addr_q  <= addr_d;
            skip_q  <= skip_d;
            req_q   <= req_d;
            stale_q <= stale_d;
        end
    end

    assign mem_req    = req_q;
    assign mem_addr   = addr_q;
    assign mbr1       = buf_q[0];
    assign mbr2       = {buf_q[0], buf_q[1]};
    assign mbr1_valid = (count_q >= 4'd1);
    assign mbr2_valid = (count_q >= 4'd2);
    assign pc         = pc_q;

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: byte-queue reference model compared every cycle, plus directed literal checks.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pc_load = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic        consume1 = 1'b0;
    logic        consume2 = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_req;
    logic [29:0] mem_addr;
    logic [7:0]  mbr1;
    logic [15:0] mbr2;
    logic        mbr1_valid;
    logic        mbr2_valid;
    logic [31:0] pc;

    ifu dut (
        .clk(clk), .rst(rst), .pc_load(pc_load), .pc_in(pc_in),
        .consume1(consume1), .consume2(consume2),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mbr1(mbr1), .mbr2(mbr2), .mbr1_valid(mbr1_valid), .mbr2_valid(mbr2_valid), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model: a byte queue plus the fetch handshake state.
    logic [7:0]  m_q [$];
    logic [31:0] m_pc = 32'd0;
    logic [29:0] m_fptr = 30'd0;
    logic [29:0] m_addr = 30'd0;
    logic [1:0]  m_skip = 2'd0;
    logic        m_req = 1'b0;
    logic        m_stale = 1'b0;
    int          m_n;
    logic        m_acc;

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            m_q.delete();
            m_pc = 32'd0; m_fptr = 30'd0; m_addr = 30'd0;
            m_skip = 2'd0; m_req = 1'b0; m_stale = 1'b0;
        end else begin
            m_n   = m_q.size();
            m_acc = m_req && mem_ack;
            if (pc_load) begin
                m_q.delete();
                m_pc   = pc_in;
                m_fptr = pc_in[31:2];
                m_skip = pc_in[1:0];
                if (m_req && !mem_ack) m_stale = 1'b1;
                if (m_acc) begin
                    m_req = 1'b0;
                    m_stale = 1'b0;
                end
            end else begin
                if (consume2 && m_n >= 2) begin
                    void'(m_q.pop_front());
                    void'(m_q.pop_front());
                    m_pc = m_pc + 32'd2;
                end else if (consume1 && m_n >= 1) begin
                    void'(m_q.pop_front());
                    m_pc = m_pc + 32'd1;
                end
                if (m_acc) begin
                    if (!m_stale) begin
                        for (int b = int'(m_skip); b < 4; b++) m_q.push_back(mem_rdata[31 - 8*b -: 8]);
                        m_fptr = m_fptr + 30'd1;
                        m_skip = 2'd0;
                    end
                    m_stale = 1'b0;
                    m_req = 1'b0;
                end else if (!m_req && m_n <= 4) begin
                    m_req = 1'b1;
                    m_addr = m_fptr;
                end
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_req});
        if (m_req) chk("mem_addr", {2'b00, mem_addr}, {2'b00, m_addr});
        chk("mbr1_valid", {31'd0, mbr1_valid}, {31'd0, m_q.size() >= 1});
        chk("mbr2_valid", {31'd0, mbr2_valid}, {31'd0, m_q.size() >= 2});
        chk("pc", pc, m_pc);
        if (m_q.size() >= 1) chk("mbr1", {24'd0, mbr1}, {24'd0, m_q[0]});
        if (m_q.size() >= 2) chk("mbr2", {16'd0, mbr2}, {16'd0, m_q[0], m_q[1]});
    end

    task automatic cyc(input logic ld, input logic [31:0] pi, input logic c1, input logic c2,
                       input logic ack, input logic [31:0] rd);
        pc_load = ld; pc_in = pi; consume1 = c1; consume2 = c2; mem_ack = ack; mem_rdata = rd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},  {31'd0, mem_req}, 32'd0);
        chk({tag, "_addr"}, {2'b00, mem_addr}, 32'd0);
        chk({tag, "_mbr1"}, {24'd0, mbr1}, 32'd0);
        chk({tag, "_mbr2"}, {16'd0, mbr2}, 32'd0);
        chk({tag, "_v1"},   {31'd0, mbr1_valid}, 32'd0);
        chk({tag, "_v2"},   {31'd0, mbr2_valid}, 32'd0);
        chk({tag, "_pc"},   pc, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b1;

        // Reset release: first request at word 0, ack two cycles later.
        idle();
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", {2'b00, mem_addr}, 32'd0);
        idle();
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h10A7_3C59);
        chk("w0_mbr1", {24'd0, mbr1}, 32'h10);
        chk("w0_mbr2", {16'd0, mbr2}, 32'h10A7);
        chk("w0_count", m_q.size(), 32'd4);
        chk("w0_req_drop", {31'd0, mem_req}, 32'd0);
        idle();
        chk("w1_req", {31'd0, mem_req}, 32'd1);
        chk("w1_addr", {2'b00, mem_addr}, 32'd1);

        // consume2 coinciding with an ack.
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1122_3344);
        chk("c2ack_mbr2", {16'd0, mbr2}, 32'h3C59);
        chk("c2ack_pc", pc, 32'd2);
        chk("c2ack_count", m_q.size(), 32'd6);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("c2ack_next", {16'd0, mbr2}, 32'h1122);
        chk("c2ack_pc2", pc, 32'd4);

        // Drain and probe ignored consumes.
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("cnt1_mbr1", {24'd0, mbr1}, 32'h44);
        cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
        chk("ign_c2_pc", pc, 32'd7);
        chk("ign_c2_v1", {31'd0, mbr1_valid}, 32'd1);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("ign_c1_pc", pc, 32'd8);
        chk("ign_c1_v1", {31'd0, mbr1_valid}, 32'd0);
        chk("pend_addr", {2'b00, mem_addr}, 32'd2);

        // Redirect with a fetch outstanding: the late ack is discarded.
        cyc(1'b1, 32'h0000_0200, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("stale_hold_req", {31'd0, mem_req}, 32'd1);
        chk("stale_hold_addr", {2'b00, mem_addr}, 32'd2);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        chk("stale_v1", {31'd0, mbr1_valid}, 32'd0);
        chk("stale_req_drop", {31'd0, mem_req}, 32'd0);
        idle();
        chk("redir_req", {31'd0, mem_req}, 32'd1);
        chk("redir_addr", {2'b00, mem_addr}, 32'h80);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h0102_0304);
        chk("redir_mbr2", {16'd0, mbr2}, 32'h0102);
        chk("redir_pc", pc, 32'h200);

        // Unaligned redirect drops the leading bytes of the first word.
        cyc(1'b1, 32'h0000_0106, 1'b0, 1'b0, 1'b0, 32'd0);
        chk("ua_pc", pc, 32'h106);
        idle();
        chk("ua_addr", {2'b00, mem_addr}, 32'h41);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'hAABB_CCDD);
        chk("ua_mbr2", {16'd0, mbr2}, 32'hCCDD);
        chk("ua_count", m_q.size(), 32'd2);
        chk("ua_pc2", pc, 32'h106);

        // Redirect in the ack cycle itself, then address and pc wrap.
        idle();
        chk("ld_ack_addr", {2'b00, mem_addr}, 32'h42);
        cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
        chk("ld_ack_v1", {31'd0, mbr1_valid}, 32'd0);
        chk("ld_ack_req", {31'd0, mem_req}, 32'd0);
        idle();
        chk("wrap_addr", {2'b00, mem_addr}, 32'h3FFF_FFFF);
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h5566_7788);
        chk("wrap_mbr1", {24'd0, mbr1}, 32'h88);
        chk("wrap_v2", {31'd0, mbr2_valid}, 32'd0);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        chk("wrap_pc", pc, 32'd0);
        chk("wrap_fptr", {2'b00, mem_addr}, 32'd0);

        // Both consumes high behave as consume2.
        cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h99AA_BBCC);
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 32'd0);
        chk("both_mbr1", {24'd0, mbr1}, 32'hBB);
        chk("both_pc", pc, 32'd2);

        // Asynchronous reset in the middle of an outstanding fetch.
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1 chk_zero("async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle();
        chk("rerun_req", {31'd0, mem_req}, 32'd1);
        chk("rerun_addr", {2'b00, mem_addr}, 32'd0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
